// File: rtl/lift_pkg.sv
// Shared types and constants for the lift hall-call panel.
//
// Contents:
//   NFLOORS  - number of served floors (fixed at 4, floor codes 0..3)
//   floor_t  - 2-bit floor code
//   state_e  - panel sequencer states
//   dir_t    - current sweep direction of the call scheduler
package lift_pkg;

  localparam int unsigned NFLOORS = 4;

  typedef logic [1:0] floor_t;

  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StSelect     = 2'd1,
    StRequest    = 2'd2,
    StWaitArrive = 2'd3
  } state_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_t;

endpackage

// File: rtl/lift_call_sel.sv
// Combinational next-target selector for the lift call panel.
//
// Scans the pending-call vector relative to the car position and picks the next
// target, continuing the current sweep direction and reversing only when nothing
// is left ahead of the car.
//
// Ports:
//   pend_i    - latched pending calls, one bit per floor
//   floor_q_i - current car floor
//   dir_i     - current sweep direction
//   tgt_o     - selected target floor (valid when found_o)
//   found_o   - a target other than the current floor exists
//   flip_o    - the selected target lies behind the sweep; direction must reverse
//   here_o    - a call is pending at the current floor
module lift_call_sel
  import lift_pkg::*;
(
  input  logic [NFLOORS-1:0] pend_i,
  input  floor_t             floor_q_i,
  input  dir_t               dir_i,
  output floor_t             tgt_o,
  output logic               found_o,
  output logic               flip_o,
  output logic               here_o
);

  logic   above_found, below_found;
  floor_t above_tgt, below_tgt;

  // Nearest pending floor above (scan downwards so the lowest match wins) and
  // nearest pending floor below (scan upwards so the highest match wins).
  always_comb begin
    above_found = 1'b0;
    above_tgt   = '0;
    for (int i = NFLOORS - 1; i >= 0; i--) begin
      if (i > int'(floor_q_i) && pend_i[i]) begin
        above_found = 1'b1;
        above_tgt   = floor_t'(i);
      end
    end
  end

  always_comb begin
    below_found = 1'b0;
    below_tgt   = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      if (i < int'(floor_q_i) && pend_i[i]) begin
        below_found = 1'b1;
        below_tgt   = floor_t'(i);
      end
    end
  end

  always_comb begin
    tgt_o   = '0;
    found_o = 1'b0;
    flip_o  = 1'b0;
    here_o  = pend_i[floor_q_i];
    if (dir_i == DirUp) begin
      if (above_found) begin
        tgt_o   = above_tgt;
        found_o = 1'b1;
      end else if (below_found) begin
        tgt_o   = below_tgt;
        found_o = 1'b1;
        flip_o  = 1'b1;
      end
    end else begin
      if (below_found) begin
        tgt_o   = below_tgt;
        found_o = 1'b1;
      end else if (above_found) begin
        tgt_o   = above_tgt;
        found_o = 1'b1;
        flip_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lift_call_panel.sv
// Lift hall-call panel: latches hall buttons into pending calls, picks the next
// target with a sweep (elevator) policy and hands it to the lift controller over
// a REQ/ACK handshake, clearing the call when the car arrives.
//
// Build option: define LIFT_PANEL_TIMEOUT_EN to abort a request that is not
// acknowledged within TIMEOUT_CYC cycles (ERR pulses, calls are kept and the
// target is reselected). Without it REQUEST waits forever and ERR is tied 0.
//
// Ports:
//   CLK     - system clock, rising edge
//   RES     - asynchronous active-high reset
//   BTN     - hall call buttons (level), one bit per floor
//   FLOOR_Q - current car floor from the controller
//   ARRIVED - car stopped at FLOOR_Q
//   ACK     - controller accepted the current target
//   REQ     - target request to the controller
//   TGT     - requested target floor
//   PEND    - latched pending calls (call lamps)
//   BUSY    - sequencer not idle
//   ERR     - one-cycle pulse on ACK timeout
module lift_call_panel
  import lift_pkg::*;
#(
  parameter int unsigned NFLOORS     = lift_pkg::NFLOORS,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic               CLK,
  input  logic               RES,
  input  logic [NFLOORS-1:0] BTN,
  input  floor_t             FLOOR_Q,
  input  logic               ARRIVED,
  input  logic               ACK,
  output logic               REQ,
  output floor_t             TGT,
  output logic [NFLOORS-1:0] PEND,
  output logic               BUSY,
  output logic               ERR
);

  // The floor encoding and selector are built for exactly four floors.
  if (NFLOORS != lift_pkg::NFLOORS || TIMEOUT_CYC == 0) begin : gen_param_err
    $error("lift_call_panel: NFLOORS must be 4 and TIMEOUT_CYC must be nonzero");
  end

  state_e             state_q, state_d;
  dir_t               dir_q, dir_d;
  logic [NFLOORS-1:0] btn_q;
  logic [NFLOORS-1:0] btn_rise;
  logic [NFLOORS-1:0] pend_q, pend_d;
  logic [NFLOORS-1:0] clr;
  logic               req_q, req_d;
  floor_t             tgt_q, tgt_d;

  floor_t             sel_tgt;
  logic               sel_found, sel_flip, sel_here;

`ifdef LIFT_PANEL_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  // Only a fresh press latches; a held button has btn_q already set.
  assign btn_rise = BTN & ~btn_q;

  lift_call_sel u_call_sel (
    .pend_i    (pend_q),
    .floor_q_i (FLOOR_Q),
    .dir_i     (dir_q),
    .tgt_o     (sel_tgt),
    .found_o   (sel_found),
    .flip_o    (sel_flip),
    .here_o    (sel_here)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    req_d   = req_q;
    tgt_d   = tgt_q;
    clr     = '0;
`ifdef LIFT_PANEL_TIMEOUT_EN
    cnt_d   = '0;
    err_d   = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          state_d = StSelect;
        end
      end

      StSelect: begin
        if (sel_here) begin
          // Car is already at a calling floor: serve it without a request.
          clr[FLOOR_Q] = 1'b1;
          state_d      = StIdle;
        end else if (sel_found) begin
          tgt_d   = sel_tgt;
          req_d   = 1'b1;
          state_d = StRequest;
          if (sel_flip) begin
            dir_d = (dir_q == DirUp) ? DirDown : DirUp;
          end
        end else begin
          state_d = StIdle;
        end
      end

      StRequest: begin
        if (ACK) begin
          req_d   = 1'b0;
          state_d = StWaitArrive;
        end
`ifdef LIFT_PANEL_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          // Give up on this handshake; calls stay latched so IDLE reselects.
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      StWaitArrive: begin
        if (ARRIVED && (FLOOR_Q == tgt_q)) begin
          clr[tgt_q] = 1'b1;
          state_d    = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Clear wins over a press of the same floor in the same cycle.
    pend_d = (pend_q | btn_rise) & ~clr;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= StIdle;
      dir_q   <= DirUp;
      btn_q   <= '0;
      pend_q  <= '0;
      req_q   <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      btn_q   <= BTN;
      pend_q  <= pend_d;
      req_q   <= req_d;
      tgt_q   <= tgt_d;
    end
  end

`ifdef LIFT_PANEL_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign REQ  = req_q;
  assign TGT  = tgt_q;
  assign PEND = pend_q;
  assign BUSY = (state_q != StIdle);

endmodule

// File: tb/tb_lift_call_panel.sv
// Self-checking bench for lift_call_panel. Stimulus pushes the expected target of
// every request it provokes into a queue; a monitor pops and compares TGT each
// time REQ rises. Directed cycle-level checks cover latency, clears and reset.
module tb_lift_call_panel;

  logic       CLK = 1'b0;
  logic       RES;
  logic [3:0] BTN;
  logic [1:0] FLOOR_Q;
  logic       ARRIVED;
  logic       ACK;
  logic       REQ;
  logic [1:0] TGT;
  logic [3:0] PEND;
  logic       BUSY;
  logic       ERR;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];
  logic       req_prev = 1'b0;

  always #5 CLK = ~CLK;

  lift_call_panel dut (
    .CLK     (CLK),
    .RES     (RES),
    .BTN     (BTN),
    .FLOOR_Q (FLOOR_Q),
    .ARRIVED (ARRIVED),
    .ACK     (ACK),
    .REQ     (REQ),
    .TGT     (TGT),
    .PEND    (PEND),
    .BUSY    (BUSY),
    .ERR     (ERR)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_req(input string name, input int max);
    int n = 0;
    while (REQ !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check(name, REQ, 1);
  endtask

  task automatic ack_pulse();
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
  endtask

  // Scoreboard monitor: every new request must match the next expected target.
  always @(negedge CLK) begin
    if (REQ === 1'b1 && req_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: REQ rose with TGT=%0d, no target expected", TGT);
      end else begin
        check("req_tgt", TGT, exp_q.pop_front());
      end
    end
    req_prev = REQ;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RES     = 1'b1;
    BTN     = 4'b0000;
    FLOOR_Q = 2'd0;
    ARRIVED = 1'b0;
    ACK     = 1'b0;
    #12;
    check("rst_req", REQ, 0);
    check("rst_tgt", TGT, 0);
    check("rst_pend", PEND, 0);
    check("rst_busy", BUSY, 0);
    check("rst_err", ERR, 0);
    @(posedge CLK);
    #1;
    RES = 1'b0;
    tick();

    // Basic call to floor 2 from floor 0: latency and arrival clear.
    BTN = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    check("t1_pend_p1", PEND, 4'b0100);
    check("t1_idle_p1", BUSY, 0);
    BTN = 4'b0000;
    tick();
    check("t1_busy_p2", BUSY, 1);
    check("t1_noreq_p2", REQ, 0);
    tick();
    check("t1_req_p3", REQ, 1);
    check("t1_tgt_p3", TGT, 2);
    ack_pulse();
    check("t1_req_drop", REQ, 0);
    check("t1_busy_wait", BUSY, 1);
    FLOOR_Q = 2'd2;
    ARRIVED = 1'b1;
    tick();
    ARRIVED = 1'b0;
    check("t1_pend_clr", PEND, 0);
    check("t1_idle", BUSY, 0);

    // Floor 1 going up, calls at 0 and 3: up first, then reverse to 0.
    FLOOR_Q = 2'd1;
    BTN = 4'b1001;
    exp_q.push_back(2'd3);
    tick();
    BTN = 4'b0000;
    check("t2_pend", PEND, 4'b1001);
    wait_req("t2_req_a", 8);
    check("t2_tgt_a", TGT, 3);
    ack_pulse();
    FLOOR_Q = 2'd3;
    ARRIVED = 1'b1;
    exp_q.push_back(2'd0);
    tick();
    ARRIVED = 1'b0;
    check("t2_pend_after3", PEND, 4'b0001);
    wait_req("t2_req_b", 8);
    check("t2_tgt_b", TGT, 0);
    ack_pulse();
    FLOOR_Q = 2'd0;
    ARRIVED = 1'b1;
    tick();
    ARRIVED = 1'b0;
    check("t2_pend_done", PEND, 0);

    // Direction is now down: from floor 2 with calls at 1 and 3, serve 1 then 3.
    FLOOR_Q = 2'd2;
    BTN = 4'b1010;
    exp_q.push_back(2'd1);
    tick();
    BTN = 4'b0000;
    wait_req("t2_req_c", 8);
    check("t2_tgt_down", TGT, 1);
    ack_pulse();
    FLOOR_Q = 2'd1;
    ARRIVED = 1'b1;
    exp_q.push_back(2'd3);
    tick();
    ARRIVED = 1'b0;
    check("t2_pend_after1", PEND, 4'b1000);
    wait_req("t2_req_d", 8);
    check("t2_tgt_flip_up", TGT, 3);
    ack_pulse();
    FLOOR_Q = 2'd3;
    ARRIVED = 1'b1;
    tick();
    ARRIVED = 1'b0;
    check("t2_pend_done2", PEND, 0);
    check("t2_idle", BUSY, 0);

    // Same-floor call: latched, then cleared in SELECT with no request.
    FLOOR_Q = 2'd2;
    BTN = 4'b0100;
    tick();
    BTN = 4'b0000;
    check("t3_pend_set", PEND, 4'b0100);
    tick();
    check("t3_select", BUSY, 1);
    tick();
    check("t3_pend_clr", PEND, 0);
    check("t3_idle", BUSY, 0);
    check("t3_noreq", REQ, 0);
    tick(3);
    check("t3_noreq_late", REQ, 0);

    // Arrival at a wrong floor is ignored; clear beats a coincident press.
    FLOOR_Q = 2'd0;
    BTN = 4'b1000;
    exp_q.push_back(2'd3);
    tick();
    BTN = 4'b0000;
    wait_req("t4_req", 8);
    ack_pulse();
    FLOOR_Q = 2'd1;
    ARRIVED = 1'b1;
    tick();
    check("t4_wrong_floor_pend", PEND, 4'b1000);
    check("t4_wrong_floor_busy", BUSY, 1);
    FLOOR_Q = 2'd3;
    BTN = 4'b1000;
    tick();
    ARRIVED = 1'b0;
    check("t4_clear_wins", PEND, 0);
    check("t4_idle", BUSY, 0);
    tick();
    check("t4_held_no_relatch", PEND, 0);
    BTN = 4'b0000;
    tick();
    check("t4_still_idle", BUSY, 0);

    // ACK during SELECT is ignored; reset mid-request drops everything at once.
    FLOOR_Q = 2'd0;
    BTN = 4'b0010;
    exp_q.push_back(2'd1);
    tick();
    BTN = 4'b0000;
    tick();
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    check("t5_req_after_early_ack", REQ, 1);
    check("t5_tgt", TGT, 1);
    tick();
    check("t5_req_held", REQ, 1);
    check("t5_tgt_held", TGT, 1);
    #2;
    RES = 1'b1;
    #1;
    check("t5_rst_req", REQ, 0);
    check("t5_rst_pend", PEND, 0);
    check("t5_rst_busy", BUSY, 0);
    check("t5_rst_tgt", TGT, 0);
    @(posedge CLK);
    #1;
    RES = 1'b0;
    tick();

    // No ACK: with the timeout option the request is aborted and reissued.
    FLOOR_Q = 2'd0;
    BTN = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    BTN = 4'b0000;
    tick(2);
    check("t6_req", REQ, 1);
`ifdef LIFT_PANEL_TIMEOUT_EN
    exp_q.push_back(2'd2);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("t6_req_hold", REQ, 1);
      check("t6_no_err", ERR, 0);
    end
    tick();
    check("t6_err_pulse", ERR, 1);
    check("t6_req_drop", REQ, 0);
    check("t6_pend_kept", PEND, 4'b0100);
    tick();
    check("t6_err_one_cycle", ERR, 0);
    check("t6_req_low", REQ, 0);
    tick();
    check("t6_req_again", REQ, 1);
    check("t6_tgt_again", TGT, 2);
`else
    for (int i = 0; i < 24; i++) begin
      tick();
      check("t6_req_wait", REQ, 1);
      check("t6_err_tied", ERR, 0);
    end
`endif
    ack_pulse();
    FLOOR_Q = 2'd2;
    ARRIVED = 1'b1;
    tick();
    ARRIVED = 1'b0;
    check("t6_pend_done", PEND, 0);
    check("t6_idle", BUSY, 0);

    tick(2);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lift_call_panel.md
LIFT_CALL_PANEL -- requirements
Module: lift_call_panel

Interface
REQ-001 SHALL have parameter NFLOORS, default 4, number of floors; fixed at 4, with floor codes 0..3.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16, ACK wait limit in cycles; used only when LIFT_PANEL_TIMEOUT_EN is defined.
REQ-003 SHALL have CLK  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have RES  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have BTN  input  4  hall call buttons, level, one bit per floor.
REQ-006 SHALL have FLOOR_Q  input  2  current car floor reported by the lift controller ({Qb,Qa}).
REQ-007 SHALL have ARRIVED  input  1  controller flag: car stopped at FLOOR_Q.
REQ-008 SHALL have ACK  input  1  controller accepted the current target.
REQ-009 SHALL have REQ  output  1  target request to the controller.
REQ-010 SHALL have TGT  output  2  requested target floor ({B,A}).
REQ-011 SHALL have PEND  output  4  latched pending calls, which drive the call lamps.
REQ-012 SHALL have BUSY  output  1  high whenever state is not IDLE.
REQ-013 SHALL have ERR  output  1  one-cycle pulse on ACK timeout.

Function
REQ-014 SHALL register BTN each cycle and set PEND[i] one cycle after a rising edge on BTN[i]; a held button SHALL NOT re-latch.
REQ-015 SHALL implement the states IDLE, SELECT, REQUEST and WAIT_ARRIVE.
REQ-016 SHALL move IDLE->SELECT in the cycle after PEND becomes nonzero.
REQ-017 SHALL spend exactly one cycle in SELECT.
REQ-018 SELECT, PEND[FLOOR_Q] set: clear that bit, issue no request, return to IDLE.
REQ-019 SELECT otherwise, DIR=up: pick the lowest pending floor above FLOOR_Q; if none, pick the highest pending floor below FLOOR_Q and flip DIR to down.
REQ-020 SELECT otherwise, DIR=down: mirror of REQ-019.
REQ-021 On leaving SELECT with a target, SHALL register TGT, assert REQ and enter REQUEST.
REQ-022 SHALL hold REQ and TGT stable in REQUEST until ACK is sampled high.
REQ-023 After ACK is sampled high, SHALL deassert REQ the next cycle and enter WAIT_ARRIVE.
REQ-024 In WAIT_ARRIVE, ARRIVED with FLOOR_Q==TGT SHALL clear PEND[TGT] and return to IDLE; ARRIVED at any other floor SHALL be ignored.
REQ-025 New presses SHALL latch in every state; latching a floor never changes an in-flight TGT.
REQ-026 If a BTN edge and the clear of the same floor coincide, clear SHALL win.
REQ-027 ACK outside REQUEST SHALL be ignored.
REQ-028 Request latency SHALL be 3 cycles: BTN edge -> PEND set (+1) -> SELECT (+2) -> REQ high (+3), starting from IDLE with no same-floor call.

Reset
REQ-029 RES high SHALL asynchronously force state=IDLE, REQ=0, TGT=0, PEND=0, BUSY=0, ERR=0, DIR=up, BTN history=0 and timeout counter=0.
REQ-030 Reset mid-handshake SHALL drop REQ immediately and discard all pending calls.

Configuration
REQ-031 With LIFT_PANEL_TIMEOUT_EN defined, a counter SHALL run in REQUEST; after TIMEOUT_CYC cycles without ACK, SHALL drop REQ, pulse ERR for one cycle and return to IDLE with PEND kept, which forces a reselect.
REQ-032 Without LIFT_PANEL_TIMEOUT_EN, REQUEST SHALL wait indefinitely, ERR SHALL be tied 0, and no counter logic SHALL exist.

Structure
REQ-033 Package lift_pkg SHALL hold NFLOORS, the floor_t (2-bit) typedef, the state enum and the dir_t enum.
REQ-034 Next-target selection (REQ-018..020) SHALL be a combinational sub-module lift_call_sel with inputs PEND, FLOOR_Q, DIR and outputs tgt, found, flip and here.

Verification
REQ-035 Reset release with FLOOR_Q=0, BTN[2] pulse -> PEND=0100 at +1, REQ=1 with TGT=2 at +3; ACK -> REQ=0 next cycle; ARRIVED with FLOOR_Q=2 -> PEND=0000, BUSY=0.
REQ-036 FLOOR_Q=1, DIR=up, press floors 0 and 3 in the same cycle -> TGT=3; after arrival, next TGT=0 and DIR=down.
REQ-037 IDLE at FLOOR_Q=2, press BTN[2] -> PEND[2] set then cleared in SELECT, REQ never asserted.
REQ-038 In WAIT_ARRIVE with TGT=3: ARRIVED at FLOOR_Q=1 -> no clear; BTN[3] edge together with ARRIVED at FLOOR_Q=3 -> PEND[3]=0.
REQ-039 Assert RES while in REQUEST -> REQ=0 and PEND=0 in the same cycle without a clock edge.
REQ-040 With the macro defined, ACK held low for 16 cycles -> ERR pulses once, REQ drops, REQ reasserts with the same TGT 2 cycles later; without the macro, REQ stays high and ERR stays 0.
